// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared fixed-point format, FSM state encoding and W-bit
// add/subtract helpers for the perceptron learner.
// Optional build macro: PERCEPTRON_SATURATE_EN. When it is defined, additions
// clamp to FX_MAX/FX_MIN. When it is not defined, additions wrap.
package perceptron_pkg;

    localparam int SIGN = 1;
    localparam int Q_M  = 15;
    localparam int Q_N  = 16;
    localparam int W    = SIGN + Q_M + Q_N;
    localparam int W2   = 2 * W;

    localparam logic signed [W-1:0] FX_ONE = W'(1 << Q_N);
    localparam logic signed [W-1:0] FX_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] FX_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_MUL_1,
        S_MUL_2,
        S_MUL_B,
        S_ACTIVATE,
        S_SCALE,
        S_UPD_1,
        S_UPD_2,
        S_UPD_B
    } state_e;

    // W-bit signed addition. Overflow is only possible when both operands share a sign.
    function automatic logic signed [W-1:0] fx_add(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
`ifdef PERCEPTRON_SATURATE_EN
        logic signed [W-1:0] s;
        s = a + b;
        if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) begin
            return a[W-1] ? FX_MIN : FX_MAX;
        end
        return s;
`else
        return a + b;
`endif
    endfunction

    // W-bit signed subtraction. Overflow is only possible when the operand signs differ.
    function automatic logic signed [W-1:0] fx_sub(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
`ifdef PERCEPTRON_SATURATE_EN
        logic signed [W-1:0] s;
        s = a - b;
        if ((a[W-1] != b[W-1]) && (s[W-1] != a[W-1])) begin
            return a[W-1] ? FX_MIN : FX_MAX;
        end
        return s;
`else
        return a - b;
`endif
    endfunction

endpackage

// File: rtl/fixed_point_multiplier.sv
// fixed_point_multiplier: signed W x W product, arithmetic shift right by Q_N,
// then reduction back to W bits. The learner shares this one instance across
// every multiply state.
// Optional build macro: PERCEPTRON_SATURATE_EN. When it is defined, the
// reduction clamps to FX_MAX/FX_MIN. When it is not defined, the reduction
// truncates (wraps).
module fixed_point_multiplier
    import perceptron_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] p_o
);

    logic signed [W2-1:0] prod;
`ifdef PERCEPTRON_SATURATE_EN
    logic signed [W2-1:0] shifted;
`endif

    // Full-precision product, rescaled to Q_N fractional bits and reduced to W bits
    always_comb begin
        prod = W2'($signed(a_i)) * W2'($signed(b_i));
`ifdef PERCEPTRON_SATURATE_EN
        shifted = prod >>> Q_N;
        // The value fits in W bits only when all bits above W-1 are copies of the sign bit.
        if ((&shifted[W2-1:W-1]) || (~|shifted[W2-1:W-1])) begin
            p_o = shifted[W-1:0];
        end else if (shifted[W2-1]) begin
            p_o = FX_MIN;
        end else begin
            p_o = FX_MAX;
        end
`else
        p_o = W'(prod >>> Q_N);
`endif
    end

endmodule

// File: rtl/perceptron_learner.sv
// perceptron_learner: takes one (x1, x2, target) sample per valid/ready
// handshake. It forms w1*x1 + w2*x2 + wb*BIAS and applies a step activation.
// On a misprediction it applies w += LR*error*x, updating one weight per cycle.
// All multiplies go through a single shared fixed_point_multiplier.
// Optional build macro: PERCEPTRON_SATURATE_EN. When it is defined, the
// arithmetic saturates. When it is not defined, the arithmetic wraps.
module perceptron_learner
    import perceptron_pkg::*;
#(
    parameter logic [W-1:0] LEARNING_RATE    = 32'h0001_0000,
    parameter logic [W-1:0] INIT_WEIGHT_1    = 32'h0001_0000,
    parameter logic [W-1:0] INIT_WEIGHT_2    = 32'h0001_0000,
    parameter logic [W-1:0] INIT_WEIGHT_BIAS = 32'h0000_4000,
    parameter logic [W-1:0] BIAS             = 32'h0001_0000
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] train_x1_in,
    input  logic [W-1:0] train_x2_in,
    input  logic [W-1:0] train_out_in,
    output logic [W-1:0] weight_1_o,
    output logic [W-1:0] weight_2_o,
    output logic [W-1:0] weight_bias_o,
    output logic [W-1:0] predict_o,
    output logic [W-1:0] error_o,
    output logic         update_done_o,
    output logic [15:0]  mistake_count_o
);

    state_e              state_q, state_d;
    logic signed [W-1:0] x1_q, x1_d;
    logic signed [W-1:0] x2_q, x2_d;
    logic signed [W-1:0] target_q, target_d;
    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] delta_q, delta_d;
    logic signed [W-1:0] w1_q, w1_d;
    logic signed [W-1:0] w2_q, w2_d;
    logic signed [W-1:0] wb_q, wb_d;
    logic signed [W-1:0] predict_q, predict_d;
    logic signed [W-1:0] error_q, error_d;
    logic [15:0]         mistake_q, mistake_d;
    logic                done_q, done_d;

    logic [W-1:0]        mul_a, mul_b, mul_p;
    logic signed [W-1:0] act_predict, act_error;

    fixed_point_multiplier u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // Next-state, operand steering for the shared multiplier, and datapath updates
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        target_d    = target_q;
        acc_d       = acc_q;
        delta_d     = delta_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        wb_d        = wb_q;
        predict_d   = predict_q;
        error_d     = error_q;
        mistake_d   = mistake_q;
        done_d      = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        act_predict = acc_q[W-1] ? '0 : FX_ONE;
        act_error   = fx_sub(target_q, act_predict);

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    x1_d     = train_x1_in;
                    x2_d     = train_x2_in;
                    target_d = train_out_in;
                    state_d  = S_MUL_1;
                end
            end
            S_MUL_1: begin
                mul_a   = w1_q;
                mul_b   = x1_q;
                acc_d   = mul_p;
                state_d = S_MUL_2;
            end
            S_MUL_2: begin
                mul_a   = w2_q;
                mul_b   = x2_q;
                acc_d   = fx_add(acc_q, mul_p);
                state_d = S_MUL_B;
            end
            S_MUL_B: begin
                mul_a   = wb_q;
                mul_b   = BIAS;
                acc_d   = fx_add(acc_q, mul_p);
                state_d = S_ACTIVATE;
            end
            S_ACTIVATE: begin
                predict_d = act_predict;
                error_d   = act_error;
                if (act_error == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (mistake_q != 16'hFFFF) begin
                        mistake_d = mistake_q + 16'd1;
                    end
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                mul_a   = LEARNING_RATE;
                mul_b   = error_q;
                delta_d = mul_p;
                state_d = S_UPD_1;
            end
            S_UPD_1: begin
                mul_a   = delta_q;
                mul_b   = x1_q;
                w1_d    = fx_add(w1_q, mul_p);
                state_d = S_UPD_2;
            end
            S_UPD_2: begin
                mul_a   = delta_q;
                mul_b   = x2_q;
                w2_d    = fx_add(w2_q, mul_p);
                state_d = S_UPD_B;
            end
            S_UPD_B: begin
                mul_a   = delta_q;
                mul_b   = BIAS;
                wb_d    = fx_add(wb_q, mul_p);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; a synchronous reset aborts any sample in flight
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments make every flop take its pre-edge value, independent of statement order.
        if (reset_i) begin
            state_q   <= S_IDLE;
            x1_q      <= '0;
            x2_q      <= '0;
            target_q  <= '0;
            acc_q     <= '0;
            delta_q   <= '0;
            w1_q      <= INIT_WEIGHT_1;
            w2_q      <= INIT_WEIGHT_2;
            wb_q      <= INIT_WEIGHT_BIAS;
            predict_q <= '0;
            error_q   <= '0;
            mistake_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            target_q  <= target_d;
            acc_q     <= acc_d;
            delta_q   <= delta_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            wb_q      <= wb_d;
            predict_q <= predict_d;
            error_q   <= error_d;
            mistake_q <= mistake_d;
            done_q    <= done_d;
        end
    end

    assign ready_o         = (state_q == S_IDLE);
    assign weight_1_o      = w1_q;
    assign weight_2_o      = w2_q;
    assign weight_bias_o   = wb_q;
    assign predict_o       = predict_q;
    assign error_o         = error_q;
    assign update_done_o   = done_q;
    assign mistake_count_o = mistake_q;

endmodule

// File: tb/tb_perceptron_learner.sv
// tb_perceptron_learner: directed, self-checking bench for perceptron_learner.
// A longint reference model predicts each sample's outcome. The expectation is
// queued when the sample is driven and is checked when update_done_o pulses.
// Honours PERCEPTRON_SATURATE_EN for the overflow expectations.
`timescale 1ns/1ps
module tb_perceptron_learner;

    localparam logic [31:0] ONE     = 32'h0001_0000;
    localparam logic [31:0] LR      = 32'h0001_0000;
    localparam logic [31:0] BIAS_IN = 32'h0001_0000;
    localparam logic [31:0] INIT_W1 = 32'h0001_0000;
    localparam logic [31:0] INIT_W2 = 32'h0001_0000;
    localparam logic [31:0] INIT_WB = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        a_valid = 1'b0, a_ready, a_done;
    logic [31:0] a_x1 = '0, a_x2 = '0, a_t = '0;
    logic [31:0] a_w1, a_w2, a_wb, a_pred, a_err;
    logic [15:0] a_mist;

    logic        b_valid = 1'b0, b_ready, b_done;
    logic [31:0] b_x1 = '0, b_x2 = '0, b_t = '0;
    logic [31:0] b_w1, b_w2, b_wb, b_pred, b_err;
    logic [15:0] b_mist;

    always #5 clk = ~clk;

    perceptron_learner dut (
        .clk_i(clk), .reset_i(reset), .valid_i(a_valid), .ready_o(a_ready),
        .train_x1_in(a_x1), .train_x2_in(a_x2), .train_out_in(a_t),
        .weight_1_o(a_w1), .weight_2_o(a_w2), .weight_bias_o(a_wb),
        .predict_o(a_pred), .error_o(a_err), .update_done_o(a_done),
        .mistake_count_o(a_mist)
    );

    perceptron_learner #(
        .INIT_WEIGHT_1(32'h7FFF_0000),
        .INIT_WEIGHT_BIAS(32'h8000_0000)
    ) dut_b (
        .clk_i(clk), .reset_i(reset), .valid_i(b_valid), .ready_o(b_ready),
        .train_x1_in(b_x1), .train_x2_in(b_x2), .train_out_in(b_t),
        .weight_1_o(b_w1), .weight_2_o(b_w2), .weight_bias_o(b_wb),
        .predict_o(b_pred), .error_o(b_err), .update_done_o(b_done),
        .mistake_count_o(b_mist)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] predict, error;
        logic [31:0] w1, w2, wb;
        logic [31:0] old_w1, old_w2, old_wb;
        logic [15:0] mist;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_w1, m_w2, m_wb;
    logic [15:0] m_mist;

    function automatic logic [31:0] m_clamp(input longint v);
`ifdef PERCEPTRON_SATURATE_EN
        if (v > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
        if (v < -64'sh0000_0000_8000_0000) return 32'h8000_0000;
`endif
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return m_clamp(p >>> 16);
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        return m_clamp(longint'($signed(a)) + longint'($signed(b)));
    endfunction

    function automatic logic [31:0] m_sub(input logic [31:0] a, input logic [31:0] b);
        return m_clamp(longint'($signed(a)) - longint'($signed(b)));
    endfunction

    task automatic model_reset();
        m_w1   = INIT_W1;
        m_w2   = INIT_W2;
        m_wb   = INIT_WB;
        m_mist = '0;
        sb_q.delete();
    endtask

    task automatic model_push(input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] t);
        exp_t        e;
        logic [31:0] acc, delta;
        e.old_w1  = m_w1;
        e.old_w2  = m_w2;
        e.old_wb  = m_wb;
        acc       = m_mul(m_w1, x1);
        acc       = m_add(acc, m_mul(m_w2, x2));
        acc       = m_add(acc, m_mul(m_wb, BIAS_IN));
        e.predict = ($signed(acc) >= 0) ? ONE : 32'h0;
        e.error   = m_sub(t, e.predict);
        if (e.error != 32'h0) begin
            if (m_mist != 16'hFFFF) m_mist = m_mist + 16'd1;
            delta = m_mul(LR, e.error);
            m_w1  = m_add(m_w1, m_mul(delta, x1));
            m_w2  = m_add(m_w2, m_mul(delta, x2));
            m_wb  = m_add(m_wb, m_mul(delta, BIAS_IN));
            e.lat = 9;
        end else begin
            e.lat = 5;
        end
        e.w1   = m_w1;
        e.w2   = m_w2;
        e.wb   = m_wb;
        e.mist = m_mist;
        sb_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard entry"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " predict"}, a_pred, e.predict);
            check({tag, " error"}, a_err, e.error);
            check({tag, " w1"}, a_w1, e.w1);
            check({tag, " w2"}, a_w2, e.w2);
            check({tag, " wb"}, a_wb, e.wb);
            check({tag, " mistakes"}, 32'(a_mist), 32'(e.mist));
        end
    endtask

    // Drive one sample at a negedge, then follow it to its done pulse.
    task automatic do_sample(input string tag, input logic [31:0] x1,
                             input logic [31:0] x2, input logic [31:0] t);
        exp_t e;
        int   wait_n;
        int   lat_seen;
        wait_n = 0;
        while (a_ready !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, " ready before accept"}, 32'(a_ready), 32'd1);
        a_valid = 1'b1;
        a_x1    = x1;
        a_x2    = x2;
        a_t     = t;
        model_push(x1, x2, t);
        e = sb_q[sb_q.size() - 1];
        @(negedge clk);
        a_valid  = 1'b0;
        lat_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) begin
                check({tag, " predict at E4"}, a_pred, e.predict);
                check({tag, " error at E4"}, a_err, e.error);
            end
            if (e.lat == 9 && k == 7) begin
                check({tag, " w1 after E6"}, a_w1, e.w1);
                check({tag, " w2 held at E6"}, a_w2, e.old_w2);
            end
            if (e.lat == 9 && k == 8) begin
                check({tag, " w2 after E7"}, a_w2, e.w2);
                check({tag, " wb held at E7"}, a_wb, e.old_wb);
            end
            if (a_done === 1'b1) begin
                lat_seen = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done latency"}, 32'(lat_seen), 32'(e.lat));
        check({tag, " ready with done"}, 32'(a_ready), 32'd1);
        check_pop(tag);
        @(negedge clk);
        check({tag, " done is one pulse"}, 32'(a_done), 32'd0);
    endtask

    logic [31:0] or_x1 [4];
    logic [31:0] or_x2 [4];
    logic [31:0] or_t  [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ep_start;
        logic [31:0] acc;
        bit          exp_rdy;
        bit          saw_done;
        int          lat_b;
        int          k_acc;

        or_x1 = '{32'h0, 32'h0, ONE, ONE};
        or_x2 = '{32'h0, ONE, 32'h0, ONE};
        or_t  = '{32'h0, ONE, ONE, ONE};

        // ---- reset state ----
        do_reset();
        check("reset ready", 32'(a_ready), 32'd1);
        check("reset w1", a_w1, INIT_W1);
        check("reset w2", a_w2, INIT_W2);
        check("reset wb", a_wb, INIT_WB);
        check("reset predict", a_pred, 32'h0);
        check("reset error", a_err, 32'h0);
        check("reset mistakes", 32'(a_mist), 32'd0);
        check("reset done", 32'(a_done), 32'd0);

        // ---- (1,1,1): zero-error path ----
        do_sample("s111", ONE, ONE, ONE);
        check("s111 predict const", a_pred, ONE);
        check("s111 error const", a_err, 32'h0);
        check("s111 w1 unchanged", a_w1, INIT_W1);
        check("s111 wb unchanged", a_wb, INIT_WB);
        check("s111 mistakes const", 32'(a_mist), 32'd0);

        // ---- (0,0,0): update path ----
        do_sample("s000", 32'h0, 32'h0, 32'h0);
        check("s000 predict const", a_pred, 32'h0001_0000);
        check("s000 error const", a_err, 32'hFFFF_0000);
        check("s000 wb const", a_wb, 32'hFFFF_4000);
        check("s000 w1 const", a_w1, 32'h0001_0000);
        check("s000 w2 const", a_w2, 32'h0001_0000);
        check("s000 mistakes const", 32'(a_mist), 32'd1);

        // ---- overflow corner on the second instance ----
        @(negedge clk);
        b_valid = 1'b1;
        b_x1    = ONE;
        b_x2    = 32'h0;
        b_t     = ONE;
        @(negedge clk);
        b_valid = 1'b0;
        lat_b   = 0;
        for (int k = 1; k <= 12; k++) begin
            if (b_done === 1'b1) begin
                lat_b = k;
                break;
            end
            @(negedge clk);
        end
        check("ovf latency", 32'(lat_b), 32'd9);
        check("ovf predict", b_pred, 32'h0);
        check("ovf error", b_err, ONE);
`ifdef PERCEPTRON_SATURATE_EN
        check("ovf w1", b_w1, 32'h7FFF_FFFF);
`else
        check("ovf w1", b_w1, 32'h8000_0000);
`endif
        check("ovf w2", b_w2, 32'h0001_0000);
        check("ovf wb", b_wb, 32'h8001_0000);
        check("ovf mistakes", 32'(b_mist), 32'd1);

        // ---- valid held high through updates ----
        do_reset();
        k_acc = 0;
        for (int c = 0; c <= 36; c++) begin
            exp_rdy = ((c % 9) == 0);
            check($sformatf("held ready c%0d", c), 32'(a_ready), 32'(exp_rdy));
            if (c > 0) check($sformatf("held done c%0d", c), 32'(a_done), 32'(exp_rdy));
            if (exp_rdy && c > 0) check_pop($sformatf("held sample c%0d", c));
            if (exp_rdy && c < 36) begin
                a_valid = 1'b1;
                a_x1    = 32'h0;
                a_x2    = 32'h0;
                a_t     = (k_acc % 2 == 1) ? ONE : 32'h0;
                model_push(a_x1, a_x2, a_t);
                k_acc++;
            end else if (c < 36) begin
                // Presented while busy: must be dropped.
                a_valid = 1'b1;
                a_x1    = ONE;
                a_x2    = ONE;
                a_t     = ONE;
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("held total mistakes", 32'(a_mist), 32'd4);

        // ---- reset at E6 of an update ----
        do_reset();
        a_valid = 1'b1;
        a_x1    = ONE;
        a_x2    = 32'h0;
        a_t     = 32'h0;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst w1", a_w1, INIT_W1);
        check("midrst w2", a_w2, INIT_W2);
        check("midrst wb", a_wb, INIT_WB);
        check("midrst ready", 32'(a_ready), 32'd1);
        check("midrst mistakes", 32'(a_mist), 32'd0);
        check("midrst predict", a_pred, 32'h0);
        check("midrst error", a_err, 32'h0);
        check("midrst done", 32'(a_done), 32'd0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (a_done === 1'b1) saw_done = 1'b1;
        end
        check("midrst no later done", 32'(saw_done), 32'd0);
        check("midrst w1 after idle", a_w1, INIT_W1);
        model_reset();

        // ---- OR-gate training, 5 epochs ----
        do_reset();
        ep_start = '0;
        for (int ep = 0; ep < 5; ep++) begin
            ep_start = a_mist;
            for (int p = 0; p < 4; p++) begin
                do_sample($sformatf("or ep%0d p%0d", ep, p), or_x1[p], or_x2[p], or_t[p]);
            end
        end
        check("or final epoch mistakes", 32'(a_mist - ep_start), 32'd0);
        for (int p = 0; p < 4; p++) begin
            acc = m_add(m_add(m_mul(a_w1, or_x1[p]), m_mul(a_w2, or_x2[p])),
                        m_mul(a_wb, BIAS_IN));
            check($sformatf("or classify p%0d", p), 32'($signed(acc) >= 0),
                  32'(or_t[p] == ONE));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perceptron_learner.md
# perceptron_learner

Receiving end of the training-sample stream for the single perceptron. It accepts one (x1, x2, target) sample per valid/ready handshake, forms the weighted sum in signed fixed point, applies a step activation, and applies the perceptron rule `w += LR·error·x` to all three weights. It sits downstream of the training sequencer and exposes live weights, per-sample prediction/error and a mistake counter.

## Interface
- `LEARNING_RATE`, default 32'h0001_0000 (1.0): learning-rate constant, signed fixed point.
- `INIT_WEIGHT_1`, default 32'h0001_0000: weight 1 value at reset.
- `INIT_WEIGHT_2`, default 32'h0001_0000: weight 2 value at reset.
- `INIT_WEIGHT_BIAS`, default 32'h0000_4000 (0.25): bias weight value at reset.
- `BIAS`, default 32'h0001_0000: constant bias input.
- `SIGN` = 1, `Q_M` = 15, `Q_N` = 16: fixed-point format. Word width W = SIGN+Q_M+Q_N.
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: sample present.
- `ready_o` out 1: learner idle and able to accept a sample.
- `train_x1_in`, `train_x2_in`, `train_out_in` in W each: inputs and target, with target 0 or 1.0.
- `weight_1_o`, `weight_2_o`, `weight_bias_o` out W each: current weights.
- `predict_o` out W: last prediction, 0 or 1.0.
- `error_o` out W: last error, target − prediction.
- `update_done_o` out 1: one-cycle pulse when a sample has been fully processed.
- `mistake_count_o` out 16: count of samples with nonzero error.

## Operation
- Handshake:
  - A sample is accepted on a rising edge with `valid_i && ready_o`.
  - Inputs are captured into registers.
  - There is no buffering. `valid_i` while `ready_o`=0 is ignored and the sample is dropped.
- FSM states: IDLE, MUL_1, MUL_2, MUL_B, ACTIVATE, SCALE, UPD_1, UPD_2, UPD_B.
- `ready_o` = (state == IDLE).
- Transitions:
  - MUL_1: acc = w1·x1.
  - MUL_2: acc += w2·x2.
  - MUL_B: acc += wb·BIAS.
  - ACTIVATE: predict = (acc ≥ 0) ? 1.0 : 0. error = target − predict.
    - If error == 0, go to IDLE and pulse `update_done_o`.
    - Otherwise increment `mistake_count_o` (saturates at 16'hFFFF) and go to SCALE.
  - SCALE: delta = LR·error.
  - UPD_1: w1 += delta·x1.
  - UPD_2: w2 += delta·x2.
  - UPD_B: wb += delta·BIAS, then go to IDLE and pulse `update_done_o`.
- Arithmetic:
  - Products are full 2W-bit signed, arithmetic-shifted right by Q_N, then reduced to W bits.
  - Additions are W-bit signed.
  - Overflow handling is per Configuration.
- Only one multiplier is used; one product is formed per state.
- Reset values:
  - Weights = INIT_* parameters.
  - `predict_o`, `error_o`, `mistake_count_o`, `update_done_o` = 0.
  - State = IDLE, so `ready_o`=1 from the first cycle after reset.
- Reset mid-operation: the sample is aborted, weights return to INIT values, and no done pulse is issued.

## Timing
- Accept at edge E0. Then:
  - E1..E3: multiply states.
  - E4: ACTIVATE exits. `predict_o`/`error_o` are registered here and held until the next sample's E4.
- Zero-error path:
  - IDLE is re-entered at E4.
  - `update_done_o` is high in the cycle after E4.
  - `ready_o` is high in that same cycle.
- Update path: `weight_1_o` changes at E6, `weight_2_o` at E7, `weight_bias_o` at E8.
  - `update_done_o` is high in the cycle after E8, and `ready_o` is high in that same cycle.
- All weights are consistent whenever `update_done_o`=1.
- Back-to-back throughput with `valid_i` held high:
  - One sample per 5 cycles on the zero-error path.
  - One sample per 9 cycles on the update path.

## Configuration
- `PERCEPTRON_SATURATE_EN` defined:
  - Product reduction and every addition saturate.
  - Limits are 32'h7FFF_FFFF and 32'h8000_0000.
- Not defined: two's-complement wrap-around (truncation).

## Structure
- `perceptron_pkg` holds:
  - The state enum.
  - W-derived localparams.
  - FX_ONE (1 << Q_N).
  - FX_MAX and FX_MIN.
- Sub-module `fixed_point_multiplier`:
  - Signed W×W multiply, shift by Q_N, reduce to W.
  - Saturation is under the same macro.
  - It is shared by all multiply states.

## Test plan
- Reset, then sample (1.0, 1.0, 1.0) with defaults:
  - acc = 2.25, predict 1.0, error 0.
  - Done pulse 5 cycles after accept.
  - Weights unchanged; mistake_count 0.
- Sample (0, 0, 0) with defaults:
  - predict 32'h0001_0000, error 32'hFFFF_0000.
  - wb becomes 32'hFFFF_4000 at E8; w1 and w2 stay 32'h0001_0000.
  - mistake_count 1.
- INIT_WEIGHT_1 = 32'h7FFF_0000, INIT_WEIGHT_BIAS = 32'h8000_0000, sample (1.0, 0, 1.0):
  - predict 0, error 1.0.
  - w1 becomes 32'h7FFF_FFFF with `PERCEPTRON_SATURATE_EN`, or 32'h8000_0000 without it.
  - wb becomes 32'h8001_0000.
- `valid_i` held high through an update:
  - Exactly one acceptance per 9 cycles.
  - Samples presented while `ready_o`=0 are not counted.
- Assert `reset_i` at E6 of an update:
  - Next cycle: weights equal INIT values, `ready_o`=1, counters 0, no done pulse.
- Run 5 OR-gate epochs with defaults:
  - Final epoch has zero mistakes.
  - Weights classify all four OR patterns correctly.
